// File: rtl/mul_256b_seq.sv
// mul_256b_seq: sequential 256x256-bit unsigned multiplier.
// A single 64x64 multiplier is fed one limb pair per cycle; each 128-bit
// partial product is shifted into place and added into a 512-bit accumulator.
// Optional build macro MUL_64B_PIPE_EN: registers the partial product (and its
// shift index) before accumulation, adding one cycle of latency.
// mul_64b_sim_model below is the simulation stand-in for the vendor 64x64 IP.

module mul_64b_sim_model (
   input  logic [63:0]  i_a,
   input  logic [63:0]  i_b,
   output logic [127:0] o_p
);
   // Full-width unsigned product
   assign o_p = {64'd0, i_a} * {64'd0, i_b};
endmodule

module mul_256b_seq #(
   parameter int unsigned N_LIMB = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_vld,
   output logic                  o_rdy,
   input  logic [64*N_LIMB-1:0]  i_a,
   input  logic [64*N_LIMB-1:0]  i_b,
   output logic                  o_vld,
   output logic [128*N_LIMB-1:0] o_p,
   output logic                  o_busy
);

   localparam int unsigned AW = 64 * N_LIMB;
   localparam int unsigned PW = 128 * N_LIMB;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_LIMB * N_LIMB - 1);
   localparam logic [CNT_W-1:0] NL   = CNT_W'(N_LIMB);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    a_q, a_d;
   logic [AW-1:0]    b_q, b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    p_q, p_d;

   logic [CNT_W-1:0] li, lj, sh;
   logic [63:0]      mul_a, mul_b;
   logic [127:0]     prod;

`ifdef MUL_64B_PIPE_EN
   logic [127:0]     pp_q, pp_d;
   logic [CNT_W-1:0] psh_q, psh_d;
   logic             pvld_q, pvld_d;
   logic             plast_q, plast_d;
   logic             issued_q, issued_d;
`endif

   // Limb selection from the product counter: a limb i = cnt/N, b limb j = cnt%N
   always_comb begin
      li    = cnt_q / NL;
      lj    = cnt_q % NL;
      sh    = li + lj;
      mul_a = 64'(a_q >> {li, 6'd0});
      mul_b = 64'(b_q >> {lj, 6'd0});
   end

   mul_64b_sim_model u_mul (
      .i_a (mul_a),
      .i_b (mul_b),
      .o_p (prod)
   );

   // Next-state, datapath and accumulation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      p_d     = p_q;
`ifdef MUL_64B_PIPE_EN
      pp_d     = pp_q;
      psh_d    = psh_q;
      pvld_d   = pvld_q;
      plast_d  = plast_q;
      issued_d = issued_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_vld) begin
               a_d     = i_a;
               b_d     = i_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_MUL;
`ifdef MUL_64B_PIPE_EN
               pp_d     = '0;
               psh_d    = '0;
               pvld_d   = 1'b0;
               plast_d  = 1'b0;
               issued_d = 1'b0;
`endif
            end
         end
         ST_MUL: begin
`ifdef MUL_64B_PIPE_EN
            // Issue side: drive limb pair cnt and capture its product
            if (!issued_q) begin
               pp_d    = prod;
               psh_d   = sh;
               pvld_d  = 1'b1;
               plast_d = (cnt_q == LAST);
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST) issued_d = 1'b1;
            end else begin
               pvld_d  = 1'b0;
            end
            // Accumulate side: consume the product issued one cycle earlier
            if (pvld_q) begin
               acc_d = acc_q + (PW'(pp_q) << {psh_q, 6'd0});
               if (plast_q) begin
                  p_d     = acc_d;
                  state_d = ST_DONE;
               end
            end
`else
            acc_d = acc_q + (PW'(prod) << {sh, 6'd0});
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // Final sum is latched into o_p on the same edge so it is
               // valid during the DONE cycle
               p_d     = acc_d;
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
      end
   end

`ifdef MUL_64B_PIPE_EN
   // Partial-product pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pp_q     <= '0;
         psh_q    <= '0;
         pvld_q   <= 1'b0;
         plast_q  <= 1'b0;
         issued_q <= 1'b0;
      end else begin
         pp_q     <= pp_d;
         psh_q    <= psh_d;
         pvld_q   <= pvld_d;
         plast_q  <= plast_d;
         issued_q <= issued_d;
      end
   end
`endif

   // Status outputs decoded from state
   always_comb begin
      o_rdy  = (state_q == ST_IDLE);
      o_busy = (state_q == ST_MUL);
      o_vld  = (state_q == ST_DONE);
      o_p    = p_q;
   end

endmodule

// File: tb/tb_mul_256b_seq.sv
// Directed testbench for mul_256b_seq (default N_LIMB=4, CNT_W=4).
module tb_mul_256b_seq;

   localparam int unsigned N_LIMB = 4;
   localparam int unsigned AW     = 64 * N_LIMB;
   localparam int unsigned PW     = 128 * N_LIMB;
`ifdef MUL_64B_PIPE_EN
   localparam int LAT = 17;
`else
   localparam int LAT = 16;
`endif
   localparam int BOUND = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_vld;
   logic [AW-1:0] i_a, i_b;
   logic          o_rdy, o_vld, o_busy;
   logic [PW-1:0] o_p;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_256b_seq #(.N_LIMB(4), .CNT_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (i_vld),
      .o_rdy  (o_rdy),
      .i_a    (i_a),
      .i_b    (i_b),
      .o_vld  (o_vld),
      .o_p    (o_p),
      .o_busy (o_busy)
   );

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Step edges (sampling #1 after each) until o_vld; n = edges since accept
   task automatic wait_vld(input logic [PW-1:0] hold, input string tag, output int n);
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < BOUND) begin
         @(posedge clk); #1;
         n++;
         seen = o_vld;
         if (n == 8) check({tag, "_hold"}, o_p, hold);
      end
   endtask

   // One isolated operation: accept, check latency, result and o_rdy return
   task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [PW-1:0] exp, input logic [PW-1:0] hold,
                         input string tag);
      int n;
      @(negedge clk);
      check({tag, "_rdy0"}, o_rdy, 1);
      i_a = a; i_b = b; i_vld = 1'b1;
      @(posedge clk); #1;
      i_vld = 1'b0;
      check({tag, "_busy"}, o_busy, 1);
      wait_vld(hold, tag, n);
      check({tag, "_lat"}, n, LAT);
      check({tag, "_p"}, o_p, exp);
      check({tag, "_rdy_in_vld"}, o_rdy, 0);
      @(posedge clk); #1;
      check({tag, "_vld_pulse"}, o_vld, 0);
      check({tag, "_rdy1"}, o_rdy, 1);
   endtask

   function automatic logic [AW-1:0] rand256();
      logic [AW-1:0] r;
      for (int unsigned k = 0; k < AW / 32; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] ones, a, b;
      logic [PW-1:0] exp, big;
      int n, vcount;

      rst = 1'b1; i_vld = 1'b0; i_a = '0; i_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", o_rdy, 1);
      check("rst_vld", o_vld, 0);
      check("rst_busy", o_busy, 0);
      check("rst_p", o_p, 0);
      rst = 1'b0;

      // 1 * 1
      run_op(256'd1, 256'd1, 512'd1, 512'd0, "one");

      // (2^256-1)^2 = 2^512 - 2^257 + 1
      ones = '1;
      exp  = 512'd1 - (512'd1 << 257);
      run_op(ones, ones, exp, 512'd1, "max");

      // 2^64 * 2^192 = 2^256
      big = 512'd1 << 256;
      run_op(256'd1 << 64, 256'd1 << 192, big, exp, "pow");

      // 0 * random = 0, o_p holds 2^256 mid-run
      run_op(256'd0, rand256(), 512'd0, big, "zero");

      // 3*5 accepted; 7*7 held on i_vld during MUL and DONE is ignored
      @(negedge clk);
      i_a = 256'd3; i_b = 256'd5; i_vld = 1'b1;
      @(posedge clk); #1;
      i_a = 256'd7; i_b = 256'd7;
      wait_vld(512'd0, "ign", n);
      check("ign_lat", n, LAT);
      check("ign_p", o_p, 512'd15);
      check("ign_rdy_in_vld", o_rdy, 0);
      @(posedge clk); #1;
      check("ign_rdy_after", o_rdy, 1);
      check("ign_busy_idle", o_busy, 0);
      @(posedge clk); #1;
      check("ign_accept2", o_busy, 1);
      i_vld = 1'b0;
      wait_vld(512'd15, "sec", n);
      check("sec_lat", n, LAT);
      check("sec_p", o_p, 512'd49);
      @(posedge clk); #1;

      // Abort with reset after 8 cycles of MUL
      @(negedge clk);
      i_a = 256'd5; i_b = 256'd6; i_vld = 1'b1;
      @(posedge clk); #1;
      i_vld = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_rdy", o_rdy, 1);
      check("abort_vld", o_vld, 0);
      check("abort_busy", o_busy, 0);
      check("abort_p", o_p, 0);
      vcount = 0;
      repeat (3) begin
         @(negedge clk);
         if (o_vld || o_busy || !o_rdy || o_p != '0) vcount++;
      end
      check("abort_held", vcount, 0);
      rst = 1'b0;
      vcount = 0;
      repeat (25) begin
         @(negedge clk);
         if (o_vld) vcount++;
      end
      check("abort_no_vld", vcount, 0);
      run_op(256'd2, 256'd9, 512'd18, 512'd0, "post");

      // Back-to-back random with i_vld held high
      i_vld = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         a   = rand256();
         b   = rand256();
         exp = {256'd0, a} * {256'd0, b};
         @(negedge clk);
         i_a = a; i_b = b;
         @(posedge clk); #1;
         wait_vld(o_p, "rnd", n);
         check("rnd_lat", n, LAT);
         check("rnd_p", o_p, exp);
         @(posedge clk); #1;
         check("rnd_rdy", o_rdy, 1);
      end
      i_vld = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
